// File: rtl/axis_lane_fifo.sv
// Per-lane AXI-Stream FWFT receive FIFO; AXIS_LANE_FIFO_FRAME_MODE_EN holds output until a whole frame is stored.
// Latency 1 cycle write-to-tvalid; rx_axis_tready drops when full, independent of tx_axis_tready.
module axis_lane_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 16
) (
  input  logic                    rx_clk,
  input  logic                    rx_rst,
  input  logic                    rx_axis_tvalid,
  output logic                    rx_axis_tready,
  input  logic [DATA_WIDTH-1:0]   rx_axis_tdata,
  input  logic                    rx_axis_tlast,
  input  logic [KEEP_WIDTH-1:0]   rx_axis_tkeep,
  output logic                    tx_axis_tvalid,
  input  logic                    tx_axis_tready,
  output logic [DATA_WIDTH-1:0]   tx_axis_tdata,
  output logic                    tx_axis_tlast,
  output logic [KEEP_WIDTH-1:0]   tx_axis_tkeep,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic [$clog2(DEPTH):0]  frame_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
  localparam logic [PW-1:0] ONE      = PW'(1);

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_fill;
  logic [PW-1:0] r_frames;
  logic          r_rdy;

  logic [EW-1:0] w_head;
  logic          w_empty;
  logic          w_head_last;
  logic          w_tx_vld;
  logic          w_wr;
  logic          w_rd;
  logic          w_frm_inc;
  logic          w_frm_dec;
  logic [PW-1:0] w_fill_nxt;
  logic [PW-1:0] w_frames_nxt;

  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_empty     = (r_fill == '0);
  assign w_head_last = w_head[0];
  assign w_wr        = rx_axis_tvalid & r_rdy;
  assign w_rd        = w_tx_vld & tx_axis_tready;
  assign w_frm_inc   = w_wr & rx_axis_tlast;
  assign w_frm_dec   = w_rd & w_head_last;

  always_comb begin
    w_fill_nxt = r_fill;
    case ({w_wr, w_rd})
      2'b10:   w_fill_nxt = r_fill + ONE;
      2'b01:   w_fill_nxt = r_fill - ONE;
      default: w_fill_nxt = r_fill;
    endcase
  end

  always_comb begin
    w_frames_nxt = r_frames;
    case ({w_frm_inc, w_frm_dec})
      2'b10:   w_frames_nxt = r_frames + ONE;
      2'b01:   w_frames_nxt = r_frames - ONE;
      default: w_frames_nxt = r_frames;
    endcase
  end

  // Ready is registered so it stays low through reset and rises on the first edge after release.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_frames <= '0;
      r_rdy    <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + ONE;
      r_fill   <= w_fill_nxt;
      r_frames <= w_frames_nxt;
      r_rdy    <= (w_fill_nxt != FULL_LVL);
    end
  end

  always_ff @(posedge rx_clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= {rx_axis_tdata, rx_axis_tkeep, rx_axis_tlast};
  end

`ifdef AXIS_LANE_FIFO_FRAME_MODE_EN
  logic r_release;
  logic r_mid;

  // r_release unblocks a frame too long to ever fit; r_mid keeps a started frame flowing.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      r_release <= 1'b0;
      r_mid     <= 1'b0;
    end else begin
      r_release <= (r_release & ~w_frm_dec) | ((r_fill == FULL_LVL) && (r_frames == '0));
      if (w_rd) r_mid <= ~w_head_last;
    end
  end

  assign w_tx_vld = ~w_empty & (r_mid | (r_frames != '0) | r_release);
`else
  assign w_tx_vld = ~w_empty;
`endif

  // Head is forced to zero when empty so reset shows clean outputs without clearing storage.
  assign {tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast} = w_empty ? '0 : w_head;
  assign tx_axis_tvalid = w_tx_vld;
  assign rx_axis_tready = r_rdy;
  assign fill_level     = r_fill;
  assign frame_count    = r_frames;

endmodule

// File: tb/tb_axis_lane_fifo.sv
// Directed bench for axis_lane_fifo; frame-mode scenarios run when AXIS_LANE_FIFO_FRAME_MODE_EN is defined.
module tb_axis_lane_fifo;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int DEPTH = 16;
  localparam int PW = 5;

  logic          rx_clk = 1'b0;
  logic          rx_rst;
  logic          rx_axis_tvalid;
  logic          rx_axis_tready;
  logic [DW-1:0] rx_axis_tdata;
  logic          rx_axis_tlast;
  logic [KW-1:0] rx_axis_tkeep;
  logic          tx_axis_tvalid;
  logic          tx_axis_tready;
  logic [DW-1:0] tx_axis_tdata;
  logic          tx_axis_tlast;
  logic [KW-1:0] tx_axis_tkeep;
  logic [PW-1:0] fill_level;
  logic [PW-1:0] frame_count;

  int errors = 0;
  int checks = 0;

  axis_lane_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(DEPTH)) dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst),
    .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tready(rx_axis_tready),
    .rx_axis_tdata(rx_axis_tdata), .rx_axis_tlast(rx_axis_tlast), .rx_axis_tkeep(rx_axis_tkeep),
    .tx_axis_tvalid(tx_axis_tvalid), .tx_axis_tready(tx_axis_tready),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tlast(tx_axis_tlast), .tx_axis_tkeep(tx_axis_tkeep),
    .fill_level(fill_level), .frame_count(frame_count)
  );

  always #5 rx_clk = ~rx_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    rx_axis_tvalid = vld;
    rx_axis_tdata  = d;
    rx_axis_tkeep  = k;
    rx_axis_tlast  = l;
  endtask

  task automatic test_reset;
    rx_rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tx_axis_tready = 1'b0;
    repeat (2) @(posedge rx_clk);
    #1;
    checks++; if (rx_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", rx_axis_tready); end
    checks++; if (tx_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", tx_axis_tvalid); end
    checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL rst_fill: got %0d want 0", fill_level); end
    checks++; if (frame_count !== 5'd0) begin errors++; $display("FAIL rst_frames: got %0d want 0", frame_count); end
    checks++; if ({tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast} !== 37'd0) begin errors++; $display("FAIL rst_head: got %h/%h/%b want 0", tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast); end
    rx_rst = 1'b0;
    tick();
    checks++; if (rx_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_release_tready: got %b want 1", rx_axis_tready); end
  endtask

`ifndef AXIS_LANE_FIFO_FRAME_MODE_EN
  task automatic test_cut_through;
    logic [DW-1:0] w;
    tx_axis_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      drive(1'b1, w, 4'h2, i == 5);
      tick();
      checks++; if (tx_axis_tvalid !== 1'b1) begin errors++; $display("FAIL ct_tvalid[%0d]: got %b want 1", i, tx_axis_tvalid); end
      checks++; if (tx_axis_tdata !== w) begin errors++; $display("FAIL ct_tdata[%0d]: got %h want %h", i, tx_axis_tdata, w); end
      checks++; if (tx_axis_tkeep !== 4'h2) begin errors++; $display("FAIL ct_tkeep[%0d]: got %h want 2", i, tx_axis_tkeep); end
      checks++; if (tx_axis_tlast !== (i == 5)) begin errors++; $display("FAIL ct_tlast[%0d]: got %b want %b", i, tx_axis_tlast, i == 5); end
      checks++; if (fill_level !== 5'd1) begin errors++; $display("FAIL ct_fill[%0d]: got %0d want 1", i, fill_level); end
    end
    checks++; if (frame_count !== 5'd1) begin errors++; $display("FAIL ct_frames_last: got %0d want 1", frame_count); end
    drive(1'b0, '0, '0, 1'b0);
    tick();
    checks++; if (tx_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ct_empty_tvalid: got %b want 0", tx_axis_tvalid); end
    checks++; if (fill_level !== 5'd0 || frame_count !== 5'd0) begin errors++; $display("FAIL ct_empty_counts: got %0d/%0d want 0/0", fill_level, frame_count); end
    tx_axis_tready = 1'b0;
  endtask
`else
  task automatic test_frame_gate;
    tx_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h600 + i, 4'hF, 1'b0);
      tick();
      checks++; if (tx_axis_tvalid !== 1'b0) begin errors++; $display("FAIL fg_gated[%0d]: got %b want 0", i, tx_axis_tvalid); end
    end
    drive(1'b1, 32'h603, 4'hF, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    checks++; if (frame_count !== 5'd1) begin errors++; $display("FAIL fg_frames: got %0d want 1", frame_count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (tx_axis_tvalid !== 1'b1) begin errors++; $display("FAIL fg_tvalid[%0d]: got %b want 1", i, tx_axis_tvalid); end
      checks++; if (tx_axis_tdata !== 32'h600 + i || tx_axis_tlast !== (i == 3)) begin errors++; $display("FAIL fg_word[%0d]: got %h/%b want %h/%b", i, tx_axis_tdata, tx_axis_tlast, 32'h600 + i, i == 3); end
      tick();
    end
    checks++; if (frame_count !== 5'd0 || tx_axis_tvalid !== 1'b0) begin errors++; $display("FAIL fg_done: got frames=%0d tvalid=%b want 0/0", frame_count, tx_axis_tvalid); end
  endtask

  task automatic test_frame_oversize;
    int wr = 0;
    int rd = 0;
    int cyc = 0;
    logic do_wr;
    tx_axis_tready = 1'b1;
    while (rd < 20 && cyc < 300) begin
      drive(wr < 20, 32'h500 + wr, 4'hF, wr == 19);
      do_wr = rx_axis_tvalid & rx_axis_tready;
      if (wr < 16) begin
        checks++; if (tx_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ov_gated: got %b want 0 after %0d writes", tx_axis_tvalid, wr); end
      end
      if (tx_axis_tvalid === 1'b1) begin
        if (rd == 0) begin
          checks++; if (wr != 16) begin errors++; $display("FAIL ov_release_point: first read after %0d writes want 16", wr); end
        end
        checks++; if (tx_axis_tdata !== 32'h500 + rd || tx_axis_tlast !== (rd == 19)) begin errors++; $display("FAIL ov_word[%0d]: got %h/%b want %h/%b", rd, tx_axis_tdata, tx_axis_tlast, 32'h500 + rd, rd == 19); end
        rd++;
      end
      tick();
      if (do_wr) wr++;
      cyc++;
    end
    drive(1'b0, '0, '0, 1'b0);
    checks++; if (rd != 20) begin errors++; $display("FAIL ov_drained: got %0d words want 20", rd); end
    checks++; if (fill_level !== 5'd0 || frame_count !== 5'd0) begin errors++; $display("FAIL ov_counts: got %0d/%0d want 0/0", fill_level, frame_count); end
    drive(1'b1, 32'h7, 4'hF, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    checks++; if (tx_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ov_release_cleared: got %b want 0", tx_axis_tvalid); end
    drive(1'b1, 32'h8, 4'hF, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    checks++; if (tx_axis_tvalid !== 1'b1 || tx_axis_tdata !== 32'h7) begin errors++; $display("FAIL ov_tail0: got %b/%h want 1/7", tx_axis_tvalid, tx_axis_tdata); end
    tick();
    checks++; if (tx_axis_tvalid !== 1'b1 || tx_axis_tdata !== 32'h8) begin errors++; $display("FAIL ov_tail1: got %b/%h want 1/8", tx_axis_tvalid, tx_axis_tdata); end
    tick();
    checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL ov_tail_empty: got %0d want 0", fill_level); end
    tx_axis_tready = 1'b0;
  endtask
`endif

  task automatic test_full;
    tx_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (rx_axis_tready !== 1'b1) begin errors++; $display("FAIL full_ready[%0d]: got %b want 1", i, rx_axis_tready); end
      drive(1'b1, 32'h100 + i, 4'hF, i == 15);
      tick();
    end
    drive(1'b1, 32'hDEADBEEF, 4'hF, 1'b0);
    checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL full_fill: got %0d want 16", fill_level); end
    checks++; if (rx_axis_tready !== 1'b0) begin errors++; $display("FAIL full_tready: got %b want 0", rx_axis_tready); end
    checks++; if (frame_count !== 5'd1) begin errors++; $display("FAIL full_frames: got %0d want 1", frame_count); end
    tick();
    checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL full_blocked: got %0d want 16", fill_level); end
    drive(1'b0, '0, '0, 1'b0);
    tx_axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (tx_axis_tvalid !== 1'b1 || tx_axis_tdata !== 32'h100 + i) begin errors++; $display("FAIL full_drain[%0d]: got %b/%h want 1/%h", i, tx_axis_tvalid, tx_axis_tdata, 32'h100 + i); end
      checks++; if (tx_axis_tlast !== (i == 15)) begin errors++; $display("FAIL full_tlast[%0d]: got %b want %b", i, tx_axis_tlast, i == 15); end
      tick();
      if (i == 0) begin
        checks++; if (rx_axis_tready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b want 1", rx_axis_tready); end
      end
    end
    checks++; if (tx_axis_tvalid !== 1'b0 || fill_level !== 5'd0 || frame_count !== 5'd0) begin errors++; $display("FAIL full_empty: got %b/%0d/%0d want 0/0/0", tx_axis_tvalid, fill_level, frame_count); end
    tx_axis_tready = 1'b0;
  endtask

  task automatic test_back_to_back;
    tx_axis_tready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h200 + k, 4'hF, 1'b1);
      tick();
    end
    tx_axis_tready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, 32'h208 + c, 4'hF, 1'b1);
      checks++; if (fill_level !== 5'd8) begin errors++; $display("FAIL b2b_fill[%0d]: got %0d want 8", c, fill_level); end
      checks++; if (tx_axis_tdata !== 32'h200 + c) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", c, tx_axis_tdata, 32'h200 + c); end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    for (int c = 40; c < 48; c++) begin
      checks++; if (tx_axis_tvalid !== 1'b1 || tx_axis_tdata !== 32'h200 + c) begin errors++; $display("FAIL b2b_tail[%0d]: got %b/%h want 1/%h", c, tx_axis_tvalid, tx_axis_tdata, 32'h200 + c); end
      tick();
    end
    checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL b2b_empty: got %0d want 0", fill_level); end
    tx_axis_tready = 1'b0;
  endtask

  task automatic test_reset_midframe;
    tx_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h300 + i, 4'hF, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    checks++; if (fill_level !== 5'd5) begin errors++; $display("FAIL mr_fill_before: got %0d want 5", fill_level); end
    #2;
    rx_rst = 1'b1;
    #1;
    checks++; if (tx_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mr_tvalid: got %b want 0", tx_axis_tvalid); end
    checks++; if (fill_level !== 5'd0 || frame_count !== 5'd0) begin errors++; $display("FAIL mr_counts: got %0d/%0d want 0/0", fill_level, frame_count); end
    checks++; if (tx_axis_tdata !== 32'd0 || rx_axis_tready !== 1'b0) begin errors++; $display("FAIL mr_outputs: got %h/%b want 0/0", tx_axis_tdata, rx_axis_tready); end
    tick();
    rx_rst = 1'b0;
    tick();
    checks++; if (rx_axis_tready !== 1'b1) begin errors++; $display("FAIL mr_ready: got %b want 1", rx_axis_tready); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h400 + i, 4'h3, i == 2);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    checks++; if (fill_level !== 5'd3 || frame_count !== 5'd1) begin errors++; $display("FAIL mr_next_counts: got %0d/%0d want 3/1", fill_level, frame_count); end
    tx_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (tx_axis_tvalid !== 1'b1 || tx_axis_tdata !== 32'h400 + i || tx_axis_tkeep !== 4'h3 || tx_axis_tlast !== (i == 2)) begin
        errors++; $display("FAIL mr_next[%0d]: got %b/%h/%h/%b want 1/%h/3/%b", i, tx_axis_tvalid, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast, 32'h400 + i, i == 2);
      end
      tick();
    end
    checks++; if (fill_level !== 5'd0 || tx_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mr_next_empty: got %0d/%b want 0/0", fill_level, tx_axis_tvalid); end
    tx_axis_tready = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef AXIS_LANE_FIFO_FRAME_MODE_EN
    test_frame_gate();
    test_frame_oversize();
`else
    test_cut_through();
`endif
    test_full();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
